ts_stub_loader: RTL and testbench

TS_STUB_LOADER -- requirements
Module: ts_stub_loader

---
 rtl/ts_stub_loader_pkg.sv | 29 ++
 rtl/ts_stub_loader_cntr.sv | 26 ++
 rtl/ts_stub_loader.sv | 156 +++++++++++++++
 tb/tb_ts_stub_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_stub_loader_pkg.sv
// Shared TS constants: layer codes, loader FSM encoding and the
// crossing-record field offsets.
package ts_stub_loader_pkg;

    typedef enum logic [1:0] {
        LAYER_IN = 2'd0,
        LAYER_A  = 2'd1,
        LAYER_B  = 2'd2,
        LAYER_C  = 2'd3
    } layer_e;

    typedef enum logic [1:0] {
        WAIT_PAGE = 2'd0,
        COLLECT   = 2'd1,
        PUSH      = 2'd2
    } state_e;

    localparam int NUM_LAYERS = 4;

    // Record layout: {page, cnt_c, cnt_b, cnt_a, cnt_in}, cnt_in at bit 0
    function automatic int rec_cnt_lsb(input int layer, input int cnt_w);
        return layer * cnt_w;
    endfunction

    function automatic int rec_page_lsb(input int cnt_w);
        return NUM_LAYERS * cnt_w;
    endfunction

endpackage

// File: rtl/ts_stub_loader_cntr.sv
// Saturating per-layer stub counter; sat flags the last usable slot
// has been consumed.
module ts_layer_cntr #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ts_stub_loader.sv
// Stub loader: pages stubs into memory per crossing, pushes counts.
// Optional TS_LOADER_OVF_CNT_EN adds a saturating drop counter ovf_cnt.
module ts_stub_loader
    import ts_stub_loader_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PAGE_W = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stub_valid,
    input  logic [1:0]                  stub_layer,
    input  logic                        bx_end,
    output logic                        loader_rdy,
    output logic                        stub_mem_wr_en,
    output logic [PAGE_W+2+CNT_W-1:0]   stub_mem_wr_adr,
    input  logic                        stub_cnt_fifo_full,
    output logic                        stub_cnt_fifo_wr_en,
    output logic [PAGE_W+4*CNT_W-1:0]   stub_cnt_fifo_din,
    input  logic                        page_release,
    output logic                        stub_drop
`ifdef TS_LOADER_OVF_CNT_EN
   ,output logic [15:0]                 ovf_cnt
`endif
);

    localparam int NUM_PAGES = 2 ** PAGE_W;
    localparam logic [PAGE_W:0] FULL_FREE = (PAGE_W+1)'(NUM_PAGES);

    logic [1:0]        rst_sync;
    logic              rst_n;
    state_e            state;
    state_e            state_nxt;
    logic [PAGE_W-1:0] cur_page;
    logic [PAGE_W:0]   free_pages;
    logic              accept;
    logic              push;
    logic              rel_ok;
    logic              clr;
    logic              sel_sat;
    logic [3:0]        inc;
    logic [3:0]        sat;
    logic [CNT_W-1:0]  cnt [NUM_LAYERS];

    // Assert passes straight through; release is retimed to clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_cntr
        assign inc[i] = accept && (stub_layer == 2'(i));
        ts_layer_cntr #(
            .CNT_W (CNT_W)
        ) u_cntr (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (inc[i]),
            .cnt   (cnt[i]),
            .sat   (sat[i])
        );
    end

    assign accept  = stub_valid && loader_rdy;
    assign sel_sat = sat[stub_layer];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_PAGE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_PAGE: if (free_pages != '0) state_nxt = COLLECT;
            COLLECT:   if (bx_end) state_nxt = PUSH;
            PUSH:      if (!stub_cnt_fifo_full) state_nxt = WAIT_PAGE;
            default:   state_nxt = WAIT_PAGE;
        endcase
    end

    always_comb begin
        loader_rdy = 1'b0;
        clr        = 1'b0;
        push       = 1'b0;
        unique case (state)
            WAIT_PAGE: clr = 1'b1;
            COLLECT:   loader_rdy = 1'b1;
            PUSH:      push = !stub_cnt_fifo_full;
            default:   clr = 1'b1;
        endcase
    end

    assign stub_cnt_fifo_wr_en = push;

    always_comb begin
        stub_cnt_fifo_din = '0;
        stub_cnt_fifo_din[rec_page_lsb(CNT_W) +: PAGE_W] = cur_page;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            stub_cnt_fifo_din[rec_cnt_lsb(l, CNT_W) +: CNT_W] = cnt[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_mem_wr_en  <= 1'b0;
            stub_mem_wr_adr <= '0;
            stub_drop       <= 1'b0;
        end else begin
            stub_mem_wr_en <= accept && !sel_sat;
            stub_drop      <= accept && sel_sat;
            if (accept) begin
                stub_mem_wr_adr <= {cur_page, stub_layer, cnt[stub_layer]};
            end
        end
    end

    // A release that coincides with a push always nets to no change
    assign rel_ok = page_release && ((free_pages != FULL_FREE) || push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_page   <= '0;
            free_pages <= FULL_FREE;
        end else begin
            if (push) begin
                cur_page <= cur_page + 1'b1;
            end
            if (push && !rel_ok) begin
                free_pages <= free_pages - 1'b1;
            end else if (rel_ok && !push) begin
                free_pages <= free_pages + 1'b1;
            end
        end
    end

`ifdef TS_LOADER_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (accept && sel_sat && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ts_stub_loader.sv
// Directed bench for ts_stub_loader: paging, saturation, backpressure,
// page release and mid-crossing reset.
module tb_ts_stub_loader;
    import ts_stub_loader_pkg::*;

    localparam int CNT_W  = 6;
    localparam int PAGE_W = 2;
    localparam int ADR_W  = PAGE_W + 2 + CNT_W;
    localparam int REC_W  = PAGE_W + 4 * CNT_W;

    logic             clk;
    logic             reset;
    logic             stub_valid;
    logic [1:0]       stub_layer;
    logic             bx_end;
    logic             loader_rdy;
    logic             stub_mem_wr_en;
    logic [ADR_W-1:0] stub_mem_wr_adr;
    logic             stub_cnt_fifo_full;
    logic             stub_cnt_fifo_wr_en;
    logic [REC_W-1:0] stub_cnt_fifo_din;
    logic             page_release;
    logic             stub_drop;
`ifdef TS_LOADER_OVF_CNT_EN
    logic [15:0]      ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int wr_cnt = 0;
    int drop_cnt = 0;
    int push_cnt = 0;
    logic [ADR_W-1:0] adr_log [$];
    logic [REC_W-1:0] din_log [$];

    int b_wr;
    int b_drop;
    int b_push;

    ts_stub_loader #(
        .CNT_W  (CNT_W),
        .PAGE_W (PAGE_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .stub_valid          (stub_valid),
        .stub_layer          (stub_layer),
        .bx_end              (bx_end),
        .loader_rdy          (loader_rdy),
        .stub_mem_wr_en      (stub_mem_wr_en),
        .stub_mem_wr_adr     (stub_mem_wr_adr),
        .stub_cnt_fifo_full  (stub_cnt_fifo_full),
        .stub_cnt_fifo_wr_en (stub_cnt_fifo_wr_en),
        .stub_cnt_fifo_din   (stub_cnt_fifo_din),
        .page_release        (page_release),
        .stub_drop           (stub_drop)
`ifdef TS_LOADER_OVF_CNT_EN
       ,.ovf_cnt             (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stub_mem_wr_en === 1'b1) begin
            wr_cnt++;
            adr_log.push_back(stub_mem_wr_adr);
        end
        if (stub_drop === 1'b1) drop_cnt++;
        if (stub_cnt_fifo_wr_en === 1'b1) begin
            push_cnt++;
            din_log.push_back(stub_cnt_fifo_din);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stub(input layer_e layer);
        stub_valid = 1'b1;
        stub_layer = layer;
        tick();
        stub_valid = 1'b0;
    endtask

    task automatic bx();
        bx_end = 1'b1;
        tick();
        bx_end = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (loader_rdy !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk(tag, 32'(loader_rdy), 32'd1);
    endtask

    task automatic mark();
        b_wr   = wr_cnt;
        b_drop = drop_cnt;
        b_push = push_cnt;
    endtask

    initial begin
        reset              = 1'b1;
        stub_valid         = 1'b0;
        stub_layer         = 2'd0;
        bx_end             = 1'b0;
        stub_cnt_fifo_full = 1'b0;
        page_release       = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("rst_rdy",     32'(loader_rdy), 32'd0);
        chk("rst_wr_en",   32'(stub_mem_wr_en), 32'd0);
        chk("rst_wr_adr",  32'(stub_mem_wr_adr), 32'd0);
        chk("rst_fifo_wr", 32'(stub_cnt_fifo_wr_en), 32'd0);
        chk("rst_din",     32'(stub_cnt_fifo_din), 32'd0);
        chk("rst_drop",    32'(stub_drop), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        wait_rdy("rdy_after_reset");

        // page 0: 3 inner, 2 a, 1 c
        mark();
        stub(LAYER_IN);
        stub(LAYER_IN);
        stub(LAYER_IN);
        stub(LAYER_A);
        stub(LAYER_A);
        stub(LAYER_C);
        bx();
        repeat (3) tick();
        chk("p0_writes", 32'(wr_cnt - b_wr), 32'd6);
        chk("p0_adr0", 32'(adr_log[b_wr]), 32'd0);
        chk("p0_adr1", 32'(adr_log[b_wr+1]), 32'd1);
        chk("p0_adr2", 32'(adr_log[b_wr+2]), 32'd2);
        chk("p0_adr_a0", 32'(adr_log[b_wr+3]), 32'd64);
        chk("p0_adr_c0", 32'(adr_log[b_wr+5]), 32'd192);
        chk("p0_pushes", 32'(push_cnt - b_push), 32'd1);
        chk("p0_din", 32'(din_log[b_push]), 32'd262275);
        wait_rdy("rdy_p1");

        // page 1: 64 stubs to layer b, last one saturates
        mark();
        stub_valid = 1'b1;
        stub_layer = LAYER_B;
        repeat (64) tick();
        stub_valid = 1'b0;
        bx();
        repeat (3) tick();
        chk("p1_writes", 32'(wr_cnt - b_wr), 32'd63);
        chk("p1_drops", 32'(drop_cnt - b_drop), 32'd1);
        chk("p1_last_adr", 32'(adr_log[b_wr+62]), 32'd446);
        chk("p1_din", 32'(din_log[b_push]), 32'd17035264);
`ifdef TS_LOADER_OVF_CNT_EN
        chk("p1_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
        wait_rdy("rdy_p2");

        // page 2: fifo full for 5 cycles during PUSH
        mark();
        stub(LAYER_IN);
        stub_cnt_fifo_full = 1'b1;
        bx();
        for (int i = 0; i < 5; i++) begin
            chk("full_wr_low", 32'(stub_cnt_fifo_wr_en), 32'd0);
            chk("full_din", 32'(stub_cnt_fifo_din), 32'd33554433);
            tick();
        end
        stub_cnt_fifo_full = 1'b0;
        #1;
        chk("full_drop_wr", 32'(stub_cnt_fifo_wr_en), 32'd1);
        repeat (3) tick();
        chk("full_pushes", 32'(push_cnt - b_push), 32'd1);
        chk("full_rec", 32'(din_log[b_push]), 32'd33554433);
        wait_rdy("rdy_p3");

        // page 3: empty crossing uses the last free page
        mark();
        bx();
        repeat (3) tick();
        chk("p3_din", 32'(din_log[b_push]), 32'd50331648);
        mark();
        stub_valid = 1'b1;
        stub_layer = LAYER_A;
        bx_end     = 1'b1;
        repeat (10) tick();
        stub_valid = 1'b0;
        bx_end     = 1'b0;
        chk("no_page_rdy", 32'(loader_rdy), 32'd0);
        chk("no_page_wr", 32'(wr_cnt - b_wr), 32'd0);
        chk("no_page_push", 32'(push_cnt - b_push), 32'd0);

        // release one page -> page 0 reused; push+release nets zero
        page_release = 1'b1;
        tick();
        page_release = 1'b0;
        wait_rdy("rdy_reuse");
        mark();
        stub(LAYER_C);
        bx();
        page_release = 1'b1;
        tick();
        page_release = 1'b0;
        repeat (2) tick();
        chk("reuse_adr", 32'(adr_log[b_wr]), 32'd192);
        chk("reuse_din", 32'(din_log[b_push]), 32'd262144);
        wait_rdy("rdy_after_push_rel");
        mark();
        bx();
        repeat (4) tick();
        chk("p1b_din", 32'(din_log[b_push]), 32'd16777216);
        chk("free_zero_rdy", 32'(loader_rdy), 32'd0);

        // reset in the middle of a crossing
        page_release = 1'b1;
        tick();
        page_release = 1'b0;
        wait_rdy("rdy_pre_abort");
        mark();
        stub(LAYER_A);
        stub(LAYER_B);
        reset = 1'b0;
        #1;
        chk("abort_rdy", 32'(loader_rdy), 32'd0);
        chk("abort_wr_en", 32'(stub_mem_wr_en), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        wait_rdy("rdy_post_abort");
        chk("abort_no_push", 32'(push_cnt - b_push), 32'd0);
        bx();
        repeat (3) tick();
        chk("abort_pushes", 32'(push_cnt - b_push), 32'd1);
        chk("abort_din", 32'(din_log[b_push]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
